multibyte_add_sequencer: RTL and testbench
==========================================

Name: multibyte_add_sequencer

Overview:
Upstream/downstream wrapper for the registered 8-bit adder stage. It accepts wide operands over a valid/ready handshake and slices them into bytes, LSB first. Each byte is issued to the 8-bit adder together with the carry from the previous byte. The block collects the returned sum bytes and carry, then presents the full-width result over a valid/ready handshake. This makes one 8-bit adder instance usable as a multi-byte ripple adder spread over several clock cycles.

Parameters:
NBYTES, 4, number of byte slices; operand width is 8*NBYTES; legal range ≥1.
ADD_LAT, 1, cycles from the adder's inputs being presented to its sum/cout being valid; legal range ≥1.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous reset, active-low.
in_valid  input  1  operand request valid.
in_ready  output  1  block can accept an operand pair.
in_a  input  8*NBYTES  operand A.
in_b  input  8*NBYTES  operand B.
in_cin  input  1  initial carry-in.
add_a  output  8  byte of A, driven to the adder's a input.
add_b  output  8  byte of B, driven to the adder's b input.
add_cin  output  1  carry driven to the adder's cin input.
add_sum  input  8  sum byte returned by the adder.
add_cout  input  1  carry returned by the adder.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts the result.
out_sum  output  8*NBYTES  full-width sum.
out_cout  output  1  final carry-out.
busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_n low, asynchronous) forces:
  - state IDLE, byte index 0, wait counter 0;
  - add_a, add_b, add_cin = 0;
  - out_sum = 0, out_cout = 0, out_valid = 0, busy = 0;
  - in_ready = 1.
  Reset mid-operation abandons the operation; no partial result is ever presented.
- in_ready = (state == IDLE), taken combinationally from the state register. out_valid = (state == DONE).
- FSM states:
  - IDLE:
    - On in_valid & in_ready: capture in_a, in_b, in_cin into operand registers; byte index = 0; carry register = in_cin; go to ISSUE.
  - ISSUE (1 cycle):
    - add_a/add_b = byte[idx] of the captured operands; add_cin = carry register.
    - Wait counter = 1; go to WAIT.
  - WAIT:
    - add_* held stable.
    - While counter < ADD_LAT: counter increments each cycle.
    - In the cycle where counter == ADD_LAT, at the clock edge:
      - out_sum byte[idx] = add_sum; carry register = add_cout.
      - If idx == NBYTES-1: out_cout = add_cout; go to DONE.
      - Otherwise: idx increments; go to ISSUE.
  - DONE:
    - out_sum and out_cout held.
    - On out_ready: go to IDLE. in_ready rises the following cycle; there is no same-cycle bypass.
- add_* outputs return to 0 in IDLE and DONE.
- Latency: out_valid is first high NBYTES*(ADD_LAT+1)+1 cycles after the acceptance edge.
  - Example: 9 cycles for NBYTES=4, ADD_LAT=1.
- Width rules:
  - Modulo 2^(8*NBYTES) sum; out_cout is the carry out of the top byte.
  - Operands are unsigned. in_cin is included in byte 0 only.
- Backpressure: out_valid stays high and out_sum/out_cout stay stable while out_ready is low. in_ready stays low throughout.
- in_valid while busy is ignored and does not corrupt the captured operands.
- out_ready while not in DONE has no effect.

Optional Feature:
- Macro: MULTIBYTE_ADD_OVF_EN.
- When defined:
  - Adds output out_ovf (1 bit): signed overflow = (A msb == B msb) && (out_sum msb != A msb), computed from the captured operands.
  - out_ovf is registered at the final capture edge, valid with out_valid, and reset to 0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
1. NBYTES=4, ADD_LAT=1: A=0x000000FF, B=0x00000001, cin=0 → out_sum=0x00000100, out_cout=0; out_valid first high exactly 9 cycles after acceptance.
2. A=0xFFFFFFFF, B=0x00000000, cin=1 → out_sum=0x00000000, out_cout=1; add_cin=1 observed on all four ISSUE cycles.
3. Backpressure: hold out_ready=0 for 5 cycles in DONE → out_valid, out_sum and out_cout stable, in_ready=0, new in_valid ignored. Release out_ready → in_ready=1 the next cycle.
4. Reset: pull rst_n low during byte 2's WAIT → all outputs go to their reset values immediately. After release, A=0x00000001, B=0x00000002 → out_sum=0x00000003.
5. ADD_LAT=2 build: A=0x12345678, B=0x11111111 → out_sum=0x23456789, out_cout=0; latency 13 cycles; add_* stable across each 2-cycle WAIT.
6. MULTIBYTE_ADD_OVF_EN build:
   - 0x7FFFFFFF + 0x00000001 → out_ovf=1, out_cout=0.
   - 0xFFFFFFFF + 0x00000001 → out_ovf=0, out_cout=1.

Source files
------------

// File: rtl/multibyte_add_sequencer.sv
// multibyte_add_sequencer
//
// Drives one registered 8-bit adder stage as a multi-byte ripple adder.
// A wide operand pair is accepted over a valid/ready handshake and split
// into bytes, least significant byte first. Each byte goes to the adder
// together with the carry returned for the previous byte. The returned sum
// bytes are collected, and the full-width result is offered over a second
// valid/ready handshake.
//
// Parameters
//   NBYTES   number of byte slices (operand width 8*NBYTES), >= 1
//   ADD_LAT  adder latency from inputs presented to sum/cout valid, >= 1
//
// Ports
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (in_ready high only in IDLE)
//   in_a, in_b, in_cin    operands and initial carry-in
//   add_a, add_b, add_cin byte operands and carry driven to the adder
//   add_sum, add_cout     sum byte and carry returned by the adder
//   out_valid / out_ready result handshake (out_valid high only in DONE)
//   out_sum, out_cout     full-width sum and carry out of the top byte
//   busy                  high in any state other than IDLE
//   out_ovf               signed overflow of the result, present only when
//                         MULTIBYTE_ADD_OVF_EN is defined
//
// Timing: the byte operands are loaded into add_* on the clock edge that
// enters ISSUE, so the adder sees them from the ISSUE cycle onwards. Each
// byte then spends ADD_LAT cycles in WAIT and the returned sum is captured on
// the edge that ends the last WAIT cycle. The result is therefore presented
// in the NBYTES*(ADD_LAT+1)+1-th cycle after the acceptance edge.

module multibyte_add_sequencer #(
  parameter int NBYTES  = 4,
  parameter int ADD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*NBYTES-1:0]   in_a,
  input  logic [8*NBYTES-1:0]   in_b,
  input  logic                  in_cin,
  output logic [7:0]            add_a,
  output logic [7:0]            add_b,
  output logic                  add_cin,
  input  logic [7:0]            add_sum,
  input  logic                  add_cout,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NBYTES-1:0]   out_sum,
`ifdef MULTIBYTE_ADD_OVF_EN
  output logic                  out_ovf,
`endif
  output logic                  out_cout,
  output logic                  busy
);

  localparam int W  = 8 * NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int CW = $clog2(ADD_LAT + 1);

  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);
  localparam logic [IW-1:0] ONE_IDX  = IW'(1);
  localparam logic [CW-1:0] LAT_CNT  = CW'(ADD_LAT);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic [W-1:0]    op_a_r;
  logic [W-1:0]    op_b_r;
  logic [IW-1:0]   idx_r;
  logic [IW-1:0]   next_idx_s;
  logic [CW-1:0]   cnt_r;
  logic [7:0]      add_a_r;
  logic [7:0]      add_b_r;
  // add_cin_r doubles as the ripple carry register between byte slices.
  logic            add_cin_r;
  logic [W-1:0]    out_sum_r;
  logic            out_cout_r;
  logic            capture_s;
  logic            last_s;
`ifdef MULTIBYTE_ADD_OVF_EN
  logic            out_ovf_r;
`endif

  // Select byte i of a wide operand; out-of-range indices yield zero.
  function automatic logic [7:0] byte_sel(input logic [W-1:0] v, input logic [IW-1:0] i);
    logic [7:0] r;
    r = 8'h00;
    for (int b = 0; b < NBYTES; b++) begin
      if (i == IW'(b)) begin
        r = v[8*b +: 8];
      end
    end
    return r;
  endfunction

`ifdef MULTIBYTE_ADD_OVF_EN
  // Two's-complement overflow: same-sign operands giving an opposite-sign sum.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction
`endif

  assign capture_s  = (state_r == WAIT) && (cnt_r == LAT_CNT);
  assign last_s     = (idx_r == LAST_IDX);
  assign next_idx_s = idx_r + ONE_IDX;

  // Handshake and status flags decoded straight from the state register.
  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == DONE);
  assign busy      = (state_r != IDLE);

  assign add_a    = add_a_r;
  assign add_b    = add_b_r;
  assign add_cin  = add_cin_r;
  assign out_sum  = out_sum_r;
  assign out_cout = out_cout_r;
`ifdef MULTIBYTE_ADD_OVF_EN
  assign out_ovf  = out_ovf_r;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_s = ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        state_s = WAIT;
      end
      WAIT: begin
        if (capture_s) begin
          if (last_s) begin
            state_s = DONE;
          end else begin
            state_s = ISSUE;
          end
        end else begin
          state_s = WAIT;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Operand capture, byte issue, latency count and result collection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a_r     <= {W{1'b0}};
      op_b_r     <= {W{1'b0}};
      idx_r      <= {IW{1'b0}};
      cnt_r      <= {CW{1'b0}};
      add_a_r    <= 8'h00;
      add_b_r    <= 8'h00;
      add_cin_r  <= 1'b0;
      out_sum_r  <= {W{1'b0}};
      out_cout_r <= 1'b0;
`ifdef MULTIBYTE_ADD_OVF_EN
      out_ovf_r  <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            op_a_r    <= in_a;
            op_b_r    <= in_b;
            idx_r     <= {IW{1'b0}};
            // Byte 0 is presented to the adder straight from the inputs.
            add_a_r   <= in_a[7:0];
            add_b_r   <= in_b[7:0];
            add_cin_r <= in_cin;
          end
        end
        ISSUE: begin
          cnt_r <= ONE_CNT;
        end
        WAIT: begin
          if (capture_s) begin
            for (int b = 0; b < NBYTES; b++) begin
              if (idx_r == IW'(b)) begin
                out_sum_r[8*b +: 8] <= add_sum;
              end
            end
            if (last_s) begin
              out_cout_r <= add_cout;
              add_a_r    <= 8'h00;
              add_b_r    <= 8'h00;
              add_cin_r  <= 1'b0;
`ifdef MULTIBYTE_ADD_OVF_EN
              // The top sum byte is being captured now, so its msb is add_sum[7].
              out_ovf_r  <= signed_ovf(op_a_r[W-1], op_b_r[W-1], add_sum[7]);
`endif
            end else begin
              idx_r     <= next_idx_s;
              add_a_r   <= byte_sel(op_a_r, next_idx_s);
              add_b_r   <= byte_sel(op_b_r, next_idx_s);
              add_cin_r <= add_cout;
            end
          end else begin
            cnt_r <= cnt_r + ONE_CNT;
          end
        end
        DONE: begin
          add_a_r   <= 8'h00;
          add_b_r   <= 8'h00;
          add_cin_r <= 1'b0;
        end
        default: begin
          add_a_r   <= 8'h00;
          add_b_r   <= 8'h00;
          add_cin_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multibyte_add_sequencer.sv
// Bench for multibyte_add_sequencer: two instances (ADD_LAT=1 and ADD_LAT=2)
// each driving its own behavioural registered adder; `sel` picks which one
// the shared stimulus task talks to.
module tb_multibyte_add_sequencer;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] in_a, in_b;
  logic        in_cin, out_ready;
  logic        in_valid1, in_valid2;
  logic        sel;

  logic        in_ready1, add_cin1, add_cout1, out_valid1, out_cout1, busy1;
  logic [7:0]  add_a1, add_b1, add_sum1;
  logic [31:0] out_sum1;
  logic        in_ready2, add_cin2, add_cout2, out_valid2, out_cout2, busy2;
  logic [7:0]  add_a2, add_b2, add_sum2;
  logic [31:0] out_sum2;
  logic        out_ovf1, out_ovf2;

  int checks = 0;
  int errors = 0;
  vec_t vecs[8];

  multibyte_add_sequencer #(.NBYTES(4), .ADD_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .add_a(add_a1), .add_b(add_b1), .add_cin(add_cin1),
    .add_sum(add_sum1), .add_cout(add_cout1),
    .out_valid(out_valid1), .out_ready(out_ready), .out_sum(out_sum1),
`ifdef MULTIBYTE_ADD_OVF_EN
    .out_ovf(out_ovf1),
`endif
    .out_cout(out_cout1), .busy(busy1)
  );

  multibyte_add_sequencer #(.NBYTES(4), .ADD_LAT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .add_a(add_a2), .add_b(add_b2), .add_cin(add_cin2),
    .add_sum(add_sum2), .add_cout(add_cout2),
    .out_valid(out_valid2), .out_ready(out_ready), .out_sum(out_sum2),
`ifdef MULTIBYTE_ADD_OVF_EN
    .out_ovf(out_ovf2),
`endif
    .out_cout(out_cout2), .busy(busy2)
  );

`ifndef MULTIBYTE_ADD_OVF_EN
  assign out_ovf1 = 1'b0;
  assign out_ovf2 = 1'b0;
`endif

  // Behavioural registered adders: 1-stage and 2-stage.
  logic [8:0] p1, q0, q1;
  always @(posedge clk) p1 <= {1'b0, add_a1} + {1'b0, add_b1} + {8'h00, add_cin1};
  always @(posedge clk) begin
    q0 <= {1'b0, add_a2} + {1'b0, add_b2} + {8'h00, add_cin2};
    q1 <= q0;
  end
  assign {add_cout1, add_sum1} = p1;
  assign {add_cout2, add_sum2} = q1;

  // Views of the selected instance.
  logic        m_in_ready, m_add_cin, m_out_valid, m_out_cout, m_busy, m_out_ovf;
  logic [7:0]  m_add_a, m_add_b;
  logic [31:0] m_out_sum;
  assign m_in_ready  = sel ? in_ready2  : in_ready1;
  assign m_add_a     = sel ? add_a2     : add_a1;
  assign m_add_b     = sel ? add_b2     : add_b1;
  assign m_add_cin   = sel ? add_cin2   : add_cin1;
  assign m_out_valid = sel ? out_valid2 : out_valid1;
  assign m_out_sum   = sel ? out_sum2   : out_sum1;
  assign m_out_cout  = sel ? out_cout2  : out_cout1;
  assign m_busy      = sel ? busy2      : busy1;
  assign m_out_ovf   = sel ? out_ovf2   : out_ovf1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Run one operation on the selected instance. hold_rdy keeps out_ready high
  // from before acceptance; bp holds the result under backpressure for bp
  // cycles while in_valid is pushed with other operands.
  task automatic run_op(input vec_t v, input bit hold_rdy, input int bp, input string tag);
    int n, k, lat;
    logic c;
    logic [8:0] t;
    lat = sel ? 2 : 1;
    n = 0;
    while (!m_in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready_before"}, 64'(m_in_ready), 64'd1);
    in_a = v.a; in_b = v.b; in_cin = v.cin; out_ready = hold_rdy;
    if (sel) in_valid2 = 1'b1; else in_valid1 = 1'b1;
    @(negedge clk);
    in_valid1 = 1'b0; in_valid2 = 1'b0;
    n = 1;
    while (!m_out_valid && n <= 40) begin
      k = (n - 1) / (lat + 1);
      if (k < 4) begin
        c = v.cin;
        for (int j = 0; j < k; j++) begin
          t = {1'b0, 8'(v.a >> (8*j))} + {1'b0, 8'(v.b >> (8*j))} + {8'h00, c};
          c = t[8];
        end
        check($sformatf("%s_add_cyc%0d", tag, n), {m_add_a, m_add_b, m_add_cin},
              {8'(v.a >> (8*k)), 8'(v.b >> (8*k)), c});
      end
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'(4 * (lat + 1) + 1));
    check({tag, "_sum"}, 64'(m_out_sum), 64'(v.sum));
    check({tag, "_cout"}, 64'(m_out_cout), 64'(v.cout));
    check({tag, "_add_idle"}, {m_add_a, m_add_b, m_add_cin}, 17'h0);
    check({tag, "_ready_done"}, {m_in_ready, m_busy}, 2'b01);
`ifdef MULTIBYTE_ADD_OVF_EN
    check({tag, "_ovf"}, 64'(m_out_ovf), 64'(v.ovf));
`endif
    for (int i = 0; i < bp; i++) begin
      in_a = ~v.a; in_b = 32'h5555AAAA; in_cin = 1'b1;
      if (sel) in_valid2 = 1'b1; else in_valid1 = 1'b1;
      @(negedge clk);
      check($sformatf("%s_bp%0d", tag, i),
            {m_out_valid, m_in_ready, m_out_cout, m_out_sum},
            {1'b1, 1'b0, v.cout, v.sum});
    end
    in_valid1 = 1'b0; in_valid2 = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_released"}, {m_in_ready, m_out_valid, m_busy}, 3'b100);
  endtask

  initial begin
    vecs[0] = '{32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0};
    vecs[2] = '{32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0};
    vecs[3] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};
    vecs[4] = '{32'h00000001, 32'h00000002, 1'b0, 32'h00000003, 1'b0, 1'b0};
    vecs[5] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
    vecs[6] = '{32'hDEADBEEF, 32'h01010101, 1'b1, 32'hDFAEBFF1, 1'b0, 1'b0};
    vecs[7] = '{32'hFFFF0000, 32'h00010000, 1'b0, 32'h00000000, 1'b1, 1'b0};

    sel = 1'b0; rst_n = 1'b0; in_a = 32'h0; in_b = 32'h0; in_cin = 1'b0;
    out_ready = 1'b0; in_valid1 = 1'b0; in_valid2 = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_flags", {in_ready1, out_valid1, busy1, out_cout1, out_ovf1}, 5'b10000);
    check("reset_add", {add_a1, add_b1, add_cin1}, 17'h0);
    check("reset_sum", 64'(out_sum1), 64'h0);
    check("reset_flags2", {in_ready2, out_valid2, busy2}, 3'b100);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i], (i == 3), (i == 2) ? 5 : 0, $sformatf("vec%0d", i));
    end

    // Reset during byte 2's WAIT cycle (cycle 6 after acceptance).
    in_a = 32'h0A0B0C0D; in_b = 32'h01020304; in_cin = 1'b0; in_valid1 = 1'b1;
    @(negedge clk);
    in_valid1 = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_op_state", {busy1, out_valid1, add_a1, add_b1}, {1'b1, 1'b0, 8'h0B, 8'h02});
    rst_n = 1'b0;
    #1;
    check("rst_flags", {in_ready1, out_valid1, busy1, out_cout1, out_ovf1}, 5'b10000);
    check("rst_add", {add_a1, add_b1, add_cin1}, 17'h0);
    check("rst_sum", 64'(out_sum1), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_idle", {in_ready1, out_valid1, busy1}, 3'b100);
    run_op(vecs[4], 1'b0, 0, "after_rst");

    sel = 1'b1;
    run_op(vecs[2], 1'b0, 0, "lat2_vec2");
    run_op(vecs[1], 1'b0, 2, "lat2_vec1");
    run_op(vecs[5], 1'b0, 0, "lat2_vec5");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
